// File: rtl/alu_pkg.sv
// Shared definitions for the Mini-ALU front end: operand width, loader
// state encoding and debounce lengths for simulation and board builds.
package alu_pkg;

  localparam int ALU_WIDTH      = 6;
  localparam int DEBOUNCE_SIM   = 4;
  localparam int DEBOUNCE_BOARD = 1_000_000;

  // Codes double as the board LED pattern; 2'b11 is unused and recovers.
  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } loader_state_t;

  // Counter width for a debouncer; never narrower than one bit.
  function automatic int debounce_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debouncer and a
// one-cycle pulse on each debounced press (release produces no pulse).
module btn_debounce
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int               CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             differ;
  logic             expire;

  // Bring the raw button into the clock domain.
  // NOTE: sequential state uses non-blocking assignments so each flop
  // samples the value its neighbour held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_in;
      sync_2 <= sync_1;
    end
  end

  // The level flips on the cycle the count of disagreeing samples would
  // reach DEBOUNCE_CYCLES; any agreeing sample restarts the count.
  assign differ = (sync_2 != level);
  assign expire = differ && (cnt == CNT_LAST);

  // Debounce counter, debounced level and registered press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= expire && !level;
      if (expire) begin
        level <= ~level;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level_out = level;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand capture stage for the Mini-ALU: debounced load presses latch
// operand A then operand B from the switches; clear returns to WAIT_A.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH           = ALU_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             operands_valid,
  output logic [1:0]       state_led
);

  logic             clr_s1;
  logic             clr_s2;
  logic             load_level;
  logic             load_pulse;
  logic             load_go;
  loader_state_t    state;
  loader_state_t    state_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_load_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_load),
    .level_out  (load_level),
    .rise_pulse (load_pulse)
  );

  // A press pulse is only meaningful while the debounced level is high.
  assign load_go = load_pulse && load_level;

  // Synchronise the clear button; it acts on every synced-high cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
    end else begin
      clr_s1 <= btn_clear;
      clr_s2 <= clr_s1;
    end
  end

  // Next-state and operand-capture decisions; clear beats a load.
  // NOTE: every signal written here gets a default first, so no latch
  // can be inferred on paths that do not assign it.
  always_comb begin
    state_nxt = state;
    a_nxt     = A;
    b_nxt     = B;
    if (clr_s2) begin
      state_nxt = WAIT_A;
      a_nxt     = '0;
      b_nxt     = '0;
    end else begin
      case (state)
        WAIT_A: begin
          if (load_go) begin
            a_nxt     = sw;
            state_nxt = WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_go) begin
            b_nxt     = sw;
            state_nxt = READY;
          end
        end
        READY: begin
          if (load_go) begin
            a_nxt     = sw;
            state_nxt = WAIT_B;
          end
        end
        default: state_nxt = WAIT_A;
      endcase
    end
  end

  // State, operand and valid registers; valid tracks the READY state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_A;
      A              <= '0;
      B              <= '0;
      operands_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      A              <= a_nxt;
      B              <= b_nxt;
      operands_valid <= (state_nxt == READY);
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a 4-cycle debounce: a table
// of press/clear steps plus hand sequences for reset, bounce and the
// clear/load collision.
module tb_alu_operand_loader;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic         btn_load;
  logic         btn_clear;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         operands_valid;
  logic [1:0]   state_led;

  int n_vec = 0;
  int n_bad = 0;

  // Bench-side record of what the outputs should currently hold.
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;
  logic         cur_v;
  logic [1:0]   cur_s;

  typedef struct {
    bit           is_clear;
    logic [W-1:0] sw;
    int           hold;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic         exp_v;
    logic [1:0]   exp_s;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  alu_operand_loader #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEBOUNCE_SIM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw             (sw),
    .btn_load       (btn_load),
    .btn_clear      (btn_clear),
    .A              (A),
    .B              (B),
    .operands_valid (operands_valid),
    .state_led      (state_led)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic ev, input logic [1:0] es);
    n_vec++;
    if (A !== ea || B !== eb || operands_valid !== ev || state_led !== es) begin
      n_bad++;
      $display("FAIL %s: got A=%h B=%h valid=%b state=%b, expected A=%h B=%h valid=%b state=%b",
               name, A, B, operands_valid, state_led, ea, eb, ev, es);
    end
  endtask

  task automatic set_cur(input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic ev, input logic [1:0] es);
    cur_a = ea;
    cur_b = eb;
    cur_v = ev;
    cur_s = es;
  endtask

  // Clean press starting at a negedge; the load must land exactly at edge k+6.
  task automatic press(input string name, input logic [W-1:0] val, input int hold,
                       input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic ev, input logic [1:0] es);
    sw       = val;
    btn_load = 1'b1;
    cycles(6);
    check({name, " before k+6"}, cur_a, cur_b, cur_v, cur_s);
    cycles(1);
    check({name, " at k+6"}, ea, eb, ev, es);
    if (hold > 7) cycles(hold - 7);
    btn_load = 1'b0;
    cycles(10);
    check({name, " after release"}, ea, eb, ev, es);
    set_cur(ea, eb, ev, es);
  endtask

  // Clear press; outputs must be cleared at edge k+2 and not before.
  task automatic clear_op(input string name);
    btn_clear = 1'b1;
    cycles(2);
    check({name, " before k+2"}, cur_a, cur_b, cur_v, cur_s);
    cycles(1);
    check({name, " at k+2"}, '0, '0, 1'b0, 2'b00);
    btn_clear = 1'b0;
    cycles(4);
    check({name, " after release"}, '0, '0, 1'b0, 2'b00);
    set_cur('0, '0, 1'b0, 2'b00);
  endtask

  initial begin
    vecs[0] = '{1'b1, 6'h00,   0, 6'h00, 6'h00, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 6'h2D,  12, 6'h2D, 6'h00, 1'b0, 2'b01};
    vecs[2] = '{1'b0, 6'h13,  12, 6'h2D, 6'h13, 1'b1, 2'b10};
    vecs[3] = '{1'b0, 6'h3F,  12, 6'h3F, 6'h13, 1'b0, 2'b01};
    vecs[4] = '{1'b0, 6'h0A,  12, 6'h3F, 6'h0A, 1'b1, 2'b10};
    vecs[5] = '{1'b1, 6'h00,   0, 6'h00, 6'h00, 1'b0, 2'b00};
    vecs[6] = '{1'b0, 6'h07,  12, 6'h07, 6'h00, 1'b0, 2'b01};
    vecs[7] = '{1'b0, 6'h38, 100, 6'h07, 6'h38, 1'b1, 2'b10};
    vecs[8] = '{1'b1, 6'h00,   0, 6'h00, 6'h00, 1'b0, 2'b00};

    // Reset held for three edges with the load button already pressed.
    rst       = 1'b1;
    btn_load  = 1'b1;
    btn_clear = 1'b0;
    sw        = 6'h15;
    cycles(3);
    check("reset values", 6'h00, 6'h00, 1'b0, 2'b00);
    rst = 1'b0;
    cycles(5);
    check("no load by edge 5 after reset", 6'h00, 6'h00, 1'b0, 2'b00);
    cycles(2);
    check("held press loads at edge 7 after reset", 6'h15, 6'h00, 1'b0, 2'b01);
    btn_load = 1'b0;
    cycles(10);
    set_cur(6'h15, 6'h00, 1'b0, 2'b01);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_clear)
        clear_op($sformatf("vec%0d clear", i));
      else
        press($sformatf("vec%0d load", i), vecs[i].sw, vecs[i].hold,
              vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_v, vecs[i].exp_s);
    end

    // Bounce: high 2 / low 1 for 21 cycles must not load.
    sw = 6'h21;
    for (int i = 0; i < 21; i++) begin
      btn_load = (i % 3 != 2);
      cycles(1);
    end
    check("bounce rejected", cur_a, cur_b, cur_v, cur_s);
    press("bounce final press", 6'h21, 12, 6'h21, 6'h00, 1'b0, 2'b01);

    // Clear and load pulse reach the FSM on the same edge in WAIT_B.
    sw       = 6'h2A;
    btn_load = 1'b1;
    cycles(4);
    btn_clear = 1'b1;
    cycles(2);
    check("collision before k+6", 6'h21, 6'h00, 1'b0, 2'b01);
    cycles(1);
    check("collision clear wins", 6'h00, 6'h00, 1'b0, 2'b00);
    btn_clear = 1'b0;
    btn_load  = 1'b0;
    cycles(10);
    check("collision no late capture", 6'h00, 6'h00, 1'b0, 2'b00);
    set_cur(6'h00, 6'h00, 1'b0, 2'b00);
    press("load after collision", 6'h0F, 12, 6'h0F, 6'h00, 1'b0, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
